// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared state encoding and size defaults for the elevator request scheduler
package elevator_pkg;

  localparam int DEF_N_FLOORS = 8;
  localparam int DEF_FLOOR_W  = $clog2(DEF_N_FLOORS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OFFER  = 2'd1,
    ST_TRAVEL = 2'd2
  } sch_state_e;

endpackage

// File: rtl/elevator_scan_picker.sv
// rtl/elevator_scan_picker.sv - combinational SCAN target selection from a pending-floor bitmap
module elevator_scan_picker
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = DEF_N_FLOORS,
  parameter int FLOOR_W  = DEF_FLOOR_W
) (
  input  logic [N_FLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0]  cur_floor_i,
  input  logic                dir_up_i,
  output logic [FLOOR_W-1:0]  pick_floor_o,
  output logic                pick_dir_up_o,
  output logic                pick_valid_o
);

  logic               at_cur;
  logic               above_found;
  logic               below_found;
  logic [FLOOR_W-1:0] above_idx;
  logic [FLOOR_W-1:0] below_idx;

  // Descending scan leaves the lowest floor above; ascending scan leaves the highest floor below.
  always_comb begin
    at_cur      = 1'b0;
    above_found = 1'b0;
    below_found = 1'b0;
    above_idx   = '0;
    below_idx   = '0;
    for (int i = N_FLOORS - 1; i >= 0; i--) begin
      if (pending_i[i] && (FLOOR_W'(i) > cur_floor_i)) begin
        above_found = 1'b1;
        above_idx   = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pending_i[i] && (FLOOR_W'(i) < cur_floor_i)) begin
        below_found = 1'b1;
        below_idx   = FLOOR_W'(i);
      end
      if (pending_i[i] && (FLOOR_W'(i) == cur_floor_i)) begin
        at_cur = 1'b1;
      end
    end
  end

  always_comb begin
    pick_valid_o  = |pending_i;
    pick_floor_o  = cur_floor_i;
    pick_dir_up_o = dir_up_i;
    if (!at_cur) begin
      if (dir_up_i) begin
        pick_floor_o  = above_found ? above_idx : below_idx;
        pick_dir_up_o = above_found;
      end else begin
        pick_floor_o  = below_found ? below_idx : above_idx;
        pick_dir_up_o = !below_found;
      end
    end
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// rtl/elevator_request_scheduler.sv - pending-call register, SCAN offer FSM and target handshake
// Optional fire-service homing is built when ELEVATOR_SCHED_HOME_EN is defined.
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = DEF_N_FLOORS,
  parameter int FLOOR_W  = DEF_FLOOR_W
) (
  input  logic                i_sch_clock,
  input  logic                i_sch_reset,
  input  logic [N_FLOORS-1:0] i_sch_req,
  input  logic [FLOOR_W-1:0]  i_sch_cur_floor,
  input  logic                i_sch_arrived,
  input  logic                i_sch_alarm,
  input  logic                i_sch_tgt_ready,
`ifdef ELEVATOR_SCHED_HOME_EN
  input  logic                i_sch_fire,
`endif
  output logic                o_sch_tgt_valid,
  output logic [FLOOR_W-1:0]  o_sch_tgt_floor,
  output logic                o_sch_dir_up,
  output logic [N_FLOORS-1:0] o_sch_pending
);

  sch_state_e          state_q;
  logic                tgt_valid_q;
  logic [FLOOR_W-1:0]  tgt_floor_q;
  logic                dir_up_q;
  logic [N_FLOORS-1:0] pending_q;
  logic [N_FLOORS-1:0] pending_d;
  logic [N_FLOORS-1:0] clr;
  logic [N_FLOORS-1:0] pending_eff;
  logic [FLOOR_W-1:0]  pick_floor;
  logic                pick_dir_up;
  logic                pick_valid;
`ifdef ELEVATOR_SCHED_HOME_EN
  logic                home_done_q;
`endif

  assign clr         = i_sch_arrived ? (N_FLOORS'(1) << i_sch_cur_floor) : '0;
  assign pending_eff = pending_q & ~clr;

  always_comb begin
    pending_d = (pending_q | i_sch_req) & ~clr;
`ifdef ELEVATOR_SCHED_HOME_EN
    if (i_sch_fire) pending_d = '0;
`endif
  end

  elevator_scan_picker #(
    .N_FLOORS (N_FLOORS),
    .FLOOR_W  (FLOOR_W)
  ) u_picker (
    .pending_i     (pending_eff),
    .cur_floor_i   (i_sch_cur_floor),
    .dir_up_i      (dir_up_q),
    .pick_floor_o  (pick_floor),
    .pick_dir_up_o (pick_dir_up),
    .pick_valid_o  (pick_valid)
  );

  always_ff @(posedge i_sch_clock or posedge i_sch_reset) begin
    if (i_sch_reset) begin
      state_q     <= ST_IDLE;
      tgt_valid_q <= 1'b0;
      tgt_floor_q <= '0;
      dir_up_q    <= 1'b1;
      pending_q   <= '0;
`ifdef ELEVATOR_SCHED_HOME_EN
      home_done_q <= 1'b0;
`endif
    end else begin
      pending_q <= pending_d;
      case (state_q)
        ST_IDLE: begin
`ifdef ELEVATOR_SCHED_HOME_EN
          if (i_sch_fire) begin
            if (!home_done_q) begin
              tgt_floor_q <= '0;
              tgt_valid_q <= 1'b1;
              home_done_q <= 1'b1;
              state_q     <= ST_OFFER;
            end
          end else
`endif
          if (pick_valid && !i_sch_alarm) begin
            tgt_floor_q <= pick_floor;
            dir_up_q    <= pick_dir_up;
            tgt_valid_q <= 1'b1;
            state_q     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (i_sch_tgt_ready) begin
            tgt_valid_q <= 1'b0;
            state_q     <= ST_TRAVEL;
          end
        end
        ST_TRAVEL: begin
          if (i_sch_arrived && (i_sch_cur_floor == tgt_floor_q)) state_q <= ST_IDLE;
        end
        default: begin
          tgt_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
`ifdef ELEVATOR_SCHED_HOME_EN
      // Fire service pins the direction down and re-arms homing once it is released.
      if (i_sch_fire) dir_up_q <= 1'b0;
      else            home_done_q <= 1'b0;
`endif
    end
  end

  assign o_sch_tgt_valid = tgt_valid_q;
  assign o_sch_tgt_floor = tgt_floor_q;
  assign o_sch_dir_up    = dir_up_q;
  assign o_sch_pending   = pending_q;

endmodule
